// File: rtl/audio_beep_scheduler_pkg.sv
// Shared types and defaults for the speaker beep scheduler.
package audio_sched_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ON   = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam int unsigned DEF_BEEP_CYC = 10_000_000;
  localparam int unsigned DEF_GAP_CYC  = 5_000_000;

  localparam logic TONE_A = 1'b0;
  localparam logic TONE_B = 1'b1;

endpackage

// File: rtl/audio_beep_scheduler_if.sv
// Request/grant bundle between the requesting task modules and the scheduler.
interface audio_beep_scheduler_if #(
  parameter int NREQ = 4
) ();
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] req_count;
  logic [NREQ-1:0]   req_tone;
  logic              cancel;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              busy;

  modport master (
    output req, req_count, req_tone, cancel,
    input  grant, done, busy
  );

  modport slave (
    input  req, req_count, req_tone, cancel,
    output grant, done, busy
  );
endinterface

// File: rtl/audio_beep_scheduler_prio_pick_onehot.sv
// Fixed-priority picker: isolates the lowest set bit of a request vector.
module prio_pick_onehot #(
  parameter int N = 4
) (
  input  logic [N-1:0] vec,
  output logic [N-1:0] onehot,
  output logic         any
);
  // Two's-complement trick keeps only the least significant set bit.
  assign onehot = vec & (~vec + N'(1));
  assign any    = |vec;
endmodule

// File: rtl/audio_beep_scheduler.sv
// Grants the speaker to one requester at a time and plays N timed beeps
// separated by silent gaps, with fixed lowest-index priority.
module audio_beep_scheduler
  import audio_sched_pkg::*;
#(
  parameter int          NREQ     = 4,
  parameter int unsigned BEEP_CYC = DEF_BEEP_CYC,
  parameter int unsigned GAP_CYC  = DEF_GAP_CYC,
  parameter int          TMR_W    = 32
) (
  input  logic                   clk100M,
  input  logic                   rst_n,
  audio_beep_scheduler_if.slave  bus,
  input  logic [11:0]            tone_a,
  input  logic [11:0]            tone_b,
  output logic [11:0]            audio_out,
  output logic                   sound_on
);

  localparam logic [TMR_W-1:0] BEEP_LAST = TMR_W'(BEEP_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYC - 1);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   pending_q, pending_d;
  logic [NREQ-1:0]   tone_q, tone_d;
  logic [3:0]        count_q [NREQ];
  logic [3:0]        count_d [NREQ];
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [3:0]        beeps_left_q, beeps_left_d;
  logic              cur_tone_q, cur_tone_d;
  logic              sound_on_q, sound_on_d;
  logic              busy_q, busy_d;

  logic [NREQ-1:0]   cap;
  logic [NREQ-1:0]   pick_onehot;
  logic              pick_any;
  logic [3:0]        owner_count;
  logic              owner_tone;

  prio_pick_onehot #(.N(NREQ)) u_pick (
    .vec    (pending_q),
    .onehot (pick_onehot),
    .any    (pick_any)
  );

  // A slot accepts one request at a time; the current owner cannot re-post.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cap
    assign cap[gi] = bus.req[gi] && (bus.req_count[4*gi +: 4] != 4'd0)
                     && !pending_q[gi] && !grant_q[gi];
  end

  always_comb begin
    owner_count = '0;
    owner_tone  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        owner_count = owner_count | count_q[i];
        owner_tone  = owner_tone | tone_q[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    tone_d       = tone_q;
    count_d      = count_q;
    grant_d      = grant_q;
    timer_d      = timer_q;
    beeps_left_d = beeps_left_q;
    cur_tone_d   = cur_tone_q;

    for (int i = 0; i < NREQ; i++) begin
      if (cap[i]) begin
        pending_d[i] = 1'b1;
        count_d[i]   = bus.req_count[4*i +: 4];
        tone_d[i]    = bus.req_tone[i];
      end
    end

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = LOAD;
          grant_d = pick_onehot;
        end
      end
      LOAD: begin
        pending_d    = pending_d & ~grant_q;
        beeps_left_d = owner_count;
        cur_tone_d   = owner_tone;
        timer_d      = '0;
        state_d      = ON;
      end
      ON: begin
        if (timer_q == BEEP_LAST) begin
          timer_d = '0;
          if (beeps_left_q == 4'd1) begin
            state_d = DONE;
          end else begin
            beeps_left_d = beeps_left_q - 4'd1;
            state_d      = GAP;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          state_d = ON;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    if (bus.cancel && (state_q != IDLE)) begin
      state_d = IDLE;
      grant_d = '0;
      timer_d = '0;
    end

    // Outputs are registered alongside the state they describe.
    sound_on_d = (state_d == ON);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE) ? grant_d : '0;
  end

  always_ff @(posedge clk100M or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      tone_q       <= '0;
      for (int i = 0; i < NREQ; i++) count_q[i] <= '0;
      grant_q      <= '0;
      done_q       <= '0;
      timer_q      <= '0;
      beeps_left_q <= '0;
      cur_tone_q   <= TONE_A;
      sound_on_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      tone_q       <= tone_d;
      count_q      <= count_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      timer_q      <= timer_d;
      beeps_left_q <= beeps_left_d;
      cur_tone_q   <= cur_tone_d;
      sound_on_q   <= sound_on_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign sound_on  = sound_on_q;
  assign audio_out = sound_on_q ? ((cur_tone_q == TONE_A) ? tone_a : tone_b) : 12'd0;

endmodule

// File: tb/tb_audio_beep_scheduler.sv
// Directed bench for audio_beep_scheduler with short beep/gap timing.
module tb_audio_beep_scheduler;

  localparam int NREQ = 4;
  localparam logic [11:0] TA = 12'hA11;
  localparam logic [11:0] TB = 12'hB22;

  logic        clk100M = 1'b0;
  logic        rst_n;
  logic [11:0] tone_a, tone_b, audio_out;
  logic        sound_on;

  int n_checks = 0;
  int n_errors = 0;

  audio_beep_scheduler_if #(.NREQ(NREQ)) bus ();

  audio_beep_scheduler #(
    .NREQ(NREQ), .BEEP_CYC(4), .GAP_CYC(2), .TMR_W(32)
  ) dut (
    .clk100M   (clk100M),
    .rst_n     (rst_n),
    .bus       (bus),
    .tone_a    (tone_a),
    .tone_b    (tone_b),
    .audio_out (audio_out),
    .sound_on  (sound_on)
  );

  always #5 clk100M = ~clk100M;

  function automatic logic [21:0] ev(input logic [11:0] aud, input logic snd,
                                     input logic bsy, input logic [3:0] gnt,
                                     input logic [3:0] dn);
    return {aud, snd, bsy, gnt, dn};
  endfunction

  function automatic logic [21:0] obs();
    return {audio_out, sound_on, bus.busy, bus.grant, bus.done};
  endfunction

  task automatic chk(input string tag, input logic [21:0] o, input logic [21:0] e);
    n_checks++;
    assert (o === e) else begin
      n_errors++;
      $error("FAIL %s: observed {aud,snd,busy,grant,done}=%h expected %h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk100M);
    #1;
  endtask

  task automatic phase(input string tag, input int n, input logic [21:0] e);
    for (int k = 0; k < n; k++) begin
      tick();
      chk(tag, obs(), e);
    end
  endtask

  task automatic post(input logic [3:0] r, input logic [15:0] cnt, input logic [3:0] tn);
    bus.req       = r;
    bus.req_count = cnt;
    bus.req_tone  = tn;
  endtask

  localparam logic [21:0] ZERO = 22'd0;

  initial begin
    rst_n      = 1'b0;
    tone_a     = TA;
    tone_b     = TB;
    bus.cancel = 1'b0;
    post(4'b0, 16'h0, 4'b0);

    phase("reset_hold", 3, ZERO);
    rst_n = 1'b1;
    phase("idle_after_reset", 20, ZERO);

    // req0: 3 beeps on tone_a
    post(4'b0001, 16'h0003, 4'b0000);
    tick();
    post(4'b0, 16'h0, 4'b0);
    chk("t2_pending_idle", obs(), ZERO);
    phase("t2_load", 1, ev(0, 0, 1, 4'b0001, 0));
    phase("t2_on1", 4, ev(TA, 1, 1, 4'b0001, 0));
    phase("t2_gap1", 2, ev(0, 0, 1, 4'b0001, 0));
    phase("t2_on2", 4, ev(TA, 1, 1, 4'b0001, 0));
    phase("t2_gap2", 2, ev(0, 0, 1, 4'b0001, 0));
    phase("t2_on3", 4, ev(TA, 1, 1, 4'b0001, 0));
    phase("t2_done", 1, ev(0, 0, 1, 4'b0001, 4'b0001));
    phase("t2_idle", 1, ZERO);
    $display("txn req0 count=3 tone=a served");

    // req1 (1 beep, tone_b) and req3 (2 beeps, tone_a) in the same cycle
    post(4'b1010, 16'h2010, 4'b0010);
    tick();
    post(4'b0, 16'h0, 4'b0);
    chk("t3_pending_idle", obs(), ZERO);
    phase("t3_load1", 1, ev(0, 0, 1, 4'b0010, 0));
    phase("t3_on1", 4, ev(TB, 1, 1, 4'b0010, 0));
    phase("t3_done1", 1, ev(0, 0, 1, 4'b0010, 4'b0010));
    phase("t3_idle_between", 1, ZERO);
    phase("t3_load3", 1, ev(0, 0, 1, 4'b1000, 0));
    phase("t3_on3a", 4, ev(TA, 1, 1, 4'b1000, 0));
    phase("t3_gap3", 2, ev(0, 0, 1, 4'b1000, 0));
    phase("t3_on3b", 4, ev(TA, 1, 1, 4'b1000, 0));
    phase("t3_done3", 1, ev(0, 0, 1, 4'b1000, 4'b1000));
    phase("t3_idle", 1, ZERO);
    $display("txn req1+req3 simultaneous served in index order");

    // req1 re-posts during its own service (dropped); req2 queues
    post(4'b0010, 16'h0020, 4'b0000);
    tick();
    post(4'b0, 16'h0, 4'b0);
    chk("t4_pending_idle", obs(), ZERO);
    phase("t4_load1", 1, ev(0, 0, 1, 4'b0010, 0));
    phase("t4_on1_first", 1, ev(TA, 1, 1, 4'b0010, 0));
    post(4'b0110, 16'h0150, 4'b0100);
    phase("t4_on1_rest", 1, ev(TA, 1, 1, 4'b0010, 0));
    post(4'b0, 16'h0, 4'b0);
    phase("t4_on1_tail", 2, ev(TA, 1, 1, 4'b0010, 0));
    phase("t4_gap1", 2, ev(0, 0, 1, 4'b0010, 0));
    phase("t4_on1b", 4, ev(TA, 1, 1, 4'b0010, 0));
    phase("t4_done1", 1, ev(0, 0, 1, 4'b0010, 4'b0010));
    phase("t4_idle_between", 1, ZERO);
    phase("t4_load2", 1, ev(0, 0, 1, 4'b0100, 0));
    phase("t4_on2", 4, ev(TB, 1, 1, 4'b0100, 0));
    phase("t4_done2", 1, ev(0, 0, 1, 4'b0100, 4'b0100));
    phase("t4_no_second_done1", 3, ZERO);
    $display("txn req1 re-post dropped, req2 served");

    // 5-beep req0 cancelled mid-gap while req3 posts in the same cycle
    post(4'b0001, 16'h0005, 4'b0000);
    tick();
    post(4'b0, 16'h0, 4'b0);
    chk("t5_pending_idle", obs(), ZERO);
    phase("t5_load0", 1, ev(0, 0, 1, 4'b0001, 0));
    phase("t5_on0", 4, ev(TA, 1, 1, 4'b0001, 0));
    phase("t5_gap0_first", 1, ev(0, 0, 1, 4'b0001, 0));
    bus.cancel = 1'b1;
    post(4'b1000, 16'h1000, 4'b1000);
    phase("t5_cancel_idle", 1, ZERO);
    bus.cancel = 1'b0;
    post(4'b0, 16'h0, 4'b0);
    phase("t5_load3", 1, ev(0, 0, 1, 4'b1000, 0));
    phase("t5_on3", 4, ev(TB, 1, 1, 4'b1000, 0));
    phase("t5_done3", 1, ev(0, 0, 1, 4'b1000, 4'b1000));
    phase("t5_idle", 2, ZERO);
    $display("txn req0 cancelled mid-gap, req3 served");

    // count=0 is a no-op
    post(4'b0100, 16'h0000, 4'b0000);
    tick();
    post(4'b0, 16'h0, 4'b0);
    chk("t6_zero_count", obs(), ZERO);
    phase("t6_zero_count_idle", 3, ZERO);
    $display("txn req2 count=0 ignored");

    // asynchronous reset mid-beep with another request pending
    post(4'b0011, 16'h0022, 4'b0000);
    tick();
    post(4'b0, 16'h0, 4'b0);
    chk("t7_pending_idle", obs(), ZERO);
    phase("t7_load0", 1, ev(0, 0, 1, 4'b0001, 0));
    phase("t7_on0", 2, ev(TA, 1, 1, 4'b0001, 0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_async_reset", obs(), ZERO);
    tick();
    rst_n = 1'b1;
    phase("t7_pending_cleared", 4, ZERO);
    $display("txn reset mid-beep cleared state");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
